// File: rtl/binary_frame_pkg.sv
// rtl/binary_frame_pkg.sv - shared widths, default timing and FSM encoding for the blob frame source
package binary_frame_pkg;

  localparam int COORD_W  = 16;
  localparam int N_POINTS = 4;

  localparam int H_ACTIVE_DEF = 200;
  localparam int H_BLANK_DEF  = 1;
  localparam int V_ACTIVE_DEF = 100;
  localparam int V_BLANK_DEF  = 2;
  localparam int BLOB_W_DEF   = 4;
  localparam int BLOB_H_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE,
    V_GAP,
    LINE,
    H_GAP
  } state_e;

endpackage

// File: rtl/blob_hit.sv
// rtl/blob_hit.sv - single square-blob membership test for one pixel
module blob_hit
  import binary_frame_pkg::*;
#(
  parameter int BLOB_W = BLOB_W_DEF,
  parameter int BLOB_H = BLOB_H_DEF
) (
  input  logic [COORD_W-1:0] h_i,
  input  logic [COORD_W-1:0] v_i,
  input  logic [COORD_W-1:0] ph_i,
  input  logic [COORD_W-1:0] pv_i,
  input  logic               en_i,
  output logic               hit_o
);

  localparam int XW = COORD_W + 1;

  // One extra bit keeps a blob placed near 0xFFFF from wrapping onto column/line 0.
  logic [XW-1:0] h_x, v_x, ph_x, pv_x, h_end, v_end;

  assign h_x   = {1'b0, h_i};
  assign v_x   = {1'b0, v_i};
  assign ph_x  = {1'b0, ph_i};
  assign pv_x  = {1'b0, pv_i};
  assign h_end = ph_x + XW'(BLOB_W - 1);
  assign v_end = pv_x + XW'(BLOB_H - 1);

  assign hit_o = en_i && (h_x >= ph_x) && (h_x <= h_end) && (v_x >= pv_x) && (v_x <= v_end);

endmodule

// File: rtl/binary_blob_frame_gen.sv
// rtl/binary_blob_frame_gen.sv - VGA-timed binary frame source rendering up to four square blobs
module binary_blob_frame_gen
  import binary_frame_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_BLANK  = H_BLANK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_BLANK  = V_BLANK_DEF,
  parameter int BLOB_W   = BLOB_W_DEF,
  parameter int BLOB_H   = BLOB_H_DEF
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                i_EN,
  input  logic [COORD_W-1:0]  i_POINTS_H_0,
  input  logic [COORD_W-1:0]  i_POINTS_H_1,
  input  logic [COORD_W-1:0]  i_POINTS_H_2,
  input  logic [COORD_W-1:0]  i_POINTS_H_3,
  input  logic [COORD_W-1:0]  i_POINTS_V_0,
  input  logic [COORD_W-1:0]  i_POINTS_V_1,
  input  logic [COORD_W-1:0]  i_POINTS_V_2,
  input  logic [COORD_W-1:0]  i_POINTS_V_3,
  input  logic [N_POINTS-1:0] i_POINTS_MASK,
  output logic                o_VGA_VS,
  output logic                o_VGA_HS,
  output logic [COORD_W-1:0]  o_H_CNT,
  output logic [COORD_W-1:0]  o_V_CNT,
  output logic                o_BINARY_FLAG,
  output logic                o_FRAME_DONE,
  output logic [COORD_W-1:0]  o_FRAME_CNT
);

  localparam logic [COORD_W-1:0] HA_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] HB_LAST = COORD_W'(H_BLANK - 1);
  localparam logic [COORD_W-1:0] VA_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] VB_LAST = COORD_W'(V_BLANK - 1);

  state_e                             state_q, state_d;
  logic [COORD_W-1:0]                 cnt_q, cnt_d;
  logic [COORD_W-1:0]                 h_q, h_d, v_q, v_d;
  logic [N_POINTS-1:0][COORD_W-1:0]   ph_q, ph_d, pv_q, pv_d;
  logic [N_POINTS-1:0]                mask_q, mask_d;
  logic                               vs_q, vs_d, hs_q, hs_d, flag_q, flag_d, done_q, done_d;
  logic [COORD_W-1:0]                 fcnt_q, fcnt_d;
  logic [N_POINTS-1:0][COORD_W-1:0]   pts_h, pts_v;
  logic [N_POINTS-1:0]                hits;

  assign pts_h = {i_POINTS_H_3, i_POINTS_H_2, i_POINTS_H_1, i_POINTS_H_0};
  assign pts_v = {i_POINTS_V_3, i_POINTS_V_2, i_POINTS_V_1, i_POINTS_V_0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    v_d     = v_q;
    ph_d    = ph_q;
    pv_d    = pv_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_EN) begin
          state_d = V_GAP;
          cnt_d   = '0;
        end
      end
      V_GAP: begin
        if (cnt_q == VB_LAST) begin
          if (i_EN) begin
            state_d = LINE;
            h_d     = '0;
            v_d     = '0;
            ph_d    = pts_h;
            pv_d    = pts_v;
            mask_d  = i_POINTS_MASK;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + COORD_W'(1);
        end
      end
      LINE: begin
        if (h_q == HA_LAST) begin
          state_d = H_GAP;
          cnt_d   = '0;
        end else begin
          h_d = h_q + COORD_W'(1);
        end
      end
      H_GAP: begin
        if (cnt_q == HB_LAST) begin
          if (v_q != VA_LAST) begin
            state_d = LINE;
            h_d     = '0;
            v_d     = v_q + COORD_W'(1);
          end else begin
            state_d = V_GAP;
            cnt_d   = '0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + COORD_W'(1);
          end
        end else begin
          cnt_d = cnt_q + COORD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hits are evaluated on next-cycle coordinates and shadows so the flag lands with H/V on the same edge.
  for (genvar k = 0; k < N_POINTS; k++) begin : g_blob
    blob_hit #(
      .BLOB_W(BLOB_W),
      .BLOB_H(BLOB_H)
    ) u_hit (
      .h_i  (h_d),
      .v_i  (v_d),
      .ph_i (ph_d[k]),
      .pv_i (pv_d[k]),
      .en_i (mask_d[k]),
      .hit_o(hits[k])
    );
  end

  always_comb begin
    vs_d   = (state_d == LINE) || (state_d == H_GAP);
    hs_d   = (state_d == LINE);
    flag_d = hs_d && (|hits);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      ph_q    <= '0;
      pv_q    <= '0;
      mask_q  <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      v_q     <= v_d;
      ph_q    <= ph_d;
      pv_q    <= pv_d;
      mask_q  <= mask_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_VGA_VS      = vs_q;
  assign o_VGA_HS      = hs_q;
  assign o_H_CNT       = h_q;
  assign o_V_CNT       = v_q;
  assign o_BINARY_FLAG = flag_q;
  assign o_FRAME_DONE  = done_q;
  assign o_FRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_binary_blob_frame_gen.sv
// tb/tb_binary_blob_frame_gen.sv - self-checking bench for binary_blob_frame_gen with a pixel-level blob model
module tb_binary_blob_frame_gen;

  localparam int HA = 40;
  localparam int HB = 2;
  localparam int VA = 24;
  localparam int VB = 3;
  localparam int BW = 3;
  localparam int BH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] pin_ph [4];
  logic [15:0] pin_pv [4];
  logic [3:0]  pin_mask;

  logic        o_vs, o_hs, o_flag, o_done;
  logic [15:0] o_h, o_v, o_fcnt;

  int checks = 0;
  int errors = 0;
  int exp_fcnt = 0;
  int last_flagged = 0;

  logic [15:0] mdl_ph [4];
  logic [15:0] mdl_pv [4];
  logic [3:0]  mdl_mask;
  logic [15:0] nxt_ph [4];
  logic [15:0] nxt_pv [4];
  logic [3:0]  nxt_mask;

  always #5 clk = ~clk;

  binary_blob_frame_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .BLOB_W(BW), .BLOB_H(BH)
  ) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .i_EN         (en),
    .i_POINTS_H_0 (pin_ph[0]),
    .i_POINTS_H_1 (pin_ph[1]),
    .i_POINTS_H_2 (pin_ph[2]),
    .i_POINTS_H_3 (pin_ph[3]),
    .i_POINTS_V_0 (pin_pv[0]),
    .i_POINTS_V_1 (pin_pv[1]),
    .i_POINTS_V_2 (pin_pv[2]),
    .i_POINTS_V_3 (pin_pv[3]),
    .i_POINTS_MASK(pin_mask),
    .o_VGA_VS     (o_vs),
    .o_VGA_HS     (o_hs),
    .o_H_CNT      (o_h),
    .o_V_CNT      (o_v),
    .o_BINARY_FLAG(o_flag),
    .o_FRAME_DONE (o_done),
    .o_FRAME_CNT  (o_fcnt)
  );

  function automatic bit model_flag(int h, int v);
    bit f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mdl_mask[k] && h >= int'(mdl_ph[k]) && h <= int'(mdl_ph[k]) + BW - 1 &&
          v >= int'(mdl_pv[k]) && v <= int'(mdl_pv[k]) + BH - 1)
        f = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [15:0] rand_coord(int lim);
    if ($urandom_range(0, 7) == 0) return 16'hFFF0 + 16'($urandom_range(0, 15));
    return 16'($urandom_range(0, lim + 1));
  endfunction

  task automatic set_pins(input int k, input int h, input int v);
    pin_ph[k] = 16'(h);
    pin_pv[k] = 16'(v);
  endtask

  // Starts in the vertical gap, follows one whole frame and stops on its FRAME_DONE cycle.
  task automatic capture_frame(input string name, input bit check_gap, input int chg_line, input int drop_line);
    int gap = 0, terr = 0, ferr = 0, dut_cnt = 0, mdl_cnt = 0, guard = 0;
    bit ef;
    while (o_vs !== 1'b1 && guard < 4 * VB + 20) begin
      @(negedge clk);
      guard++;
      if (o_vs !== 1'b1) begin
        gap++;
        if (o_done !== 1'b0 || o_hs !== 1'b0 || o_flag !== 1'b0) terr++;
      end
    end
    checks++;
    if (o_vs !== 1'b1) begin
      errors++;
      $display("FAIL %s_start VS=%b after %0d cycles, required 1", name, o_vs, guard);
      return;
    end
    if (check_gap) begin
      checks++;
      if (gap !== VB - 1) begin
        errors++;
        $display("FAIL %s_vgap low_cycles_after_done=%0d required=%0d", name, gap, VB - 1);
      end
    end
    for (int k = 0; k < 4; k++) begin
      mdl_ph[k] = pin_ph[k];
      mdl_pv[k] = pin_pv[k];
    end
    mdl_mask = pin_mask;
    for (int v = 0; v < VA; v++) begin
      for (int h = 0; h < HA; h++) begin
        if (!(v == 0 && h == 0)) @(negedge clk);
        if (o_vs !== 1'b1 || o_hs !== 1'b1 || o_h !== 16'(h) || o_v !== 16'(v) || o_done !== 1'b0) terr++;
        ef = model_flag(h, v);
        if (o_flag !== ef) ferr++;
        mdl_cnt += int'(ef);
        if (o_flag === 1'b1) dut_cnt++;
        if (h == 0 && v == chg_line) begin
          for (int k = 0; k < 4; k++) begin
            pin_ph[k] = nxt_ph[k];
            pin_pv[k] = nxt_pv[k];
          end
          pin_mask = nxt_mask;
        end
        if (h == 0 && v == drop_line) en = 1'b0;
      end
      for (int b = 0; b < HB; b++) begin
        @(negedge clk);
        if (o_vs !== 1'b1 || o_hs !== 1'b0 || o_flag !== 1'b0 || o_h !== 16'(HA - 1) ||
            o_v !== 16'(v) || o_done !== 1'b0) terr++;
      end
    end
    @(negedge clk);
    exp_fcnt = (exp_fcnt + 1) & 32'hFFFF;
    checks++;
    if (o_vs !== 1'b0 || o_hs !== 1'b0 || o_done !== 1'b1 || o_fcnt !== 16'(exp_fcnt)) begin
      errors++;
      $display("FAIL %s_done VS=%b HS=%b DONE=%b CNT=%0d required VS=0 HS=0 DONE=1 CNT=%0d",
               name, o_vs, o_hs, o_done, o_fcnt, exp_fcnt);
    end
    checks++;
    if (terr !== 0) begin
      errors++;
      $display("FAIL %s_timing bad_cycles=%0d required=0", name, terr);
    end
    checks++;
    if (ferr !== 0) begin
      errors++;
      $display("FAIL %s_flag bad_pixels=%0d required=0", name, ferr);
    end
    checks++;
    if (dut_cnt !== mdl_cnt) begin
      errors++;
      $display("FAIL %s_count flagged=%0d required=%0d", name, dut_cnt, mdl_cnt);
    end
    last_flagged = dut_cnt;
  endtask

  task automatic check_flagged(input string name, input int required);
    checks++;
    if (last_flagged !== required) begin
      errors++;
      $display("FAIL %s_hand_count flagged=%0d required=%0d", name, last_flagged, required);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 4; k++) set_pins(k, 0, 0);
    pin_mask = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_vs, o_hs, o_flag, o_done, o_h, o_v, o_fcnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs VS=%b HS=%b F=%b D=%b H=%0d V=%0d CNT=%0d required all 0",
               o_vs, o_hs, o_flag, o_done, o_h, o_v, o_fcnt);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (o_vs !== 1'b0 || o_hs !== 1'b0 || o_fcnt !== 16'd0) begin
      errors++;
      $display("FAIL idle_hold VS=%b HS=%b CNT=%0d required 0 0 0", o_vs, o_hs, o_fcnt);
    end
    exp_fcnt = 0;
  endtask

  task automatic test_plain_frames();
    pin_mask = 4'h0;
    en = 1'b1;
    capture_frame("plain0", 1'b0, -1, -1);
    check_flagged("plain0", 0);
    capture_frame("plain1", 1'b1, -1, -1);
    check_flagged("plain1", 0);
  endtask

  task automatic test_single_blob();
    set_pins(0, 10, 6);
    pin_mask = 4'b0001;
    capture_frame("single", 1'b1, -1, -1);
    check_flagged("single", BW * BH);
  endtask

  task automatic test_four_blobs();
    set_pins(0, 2, 1);
    set_pins(1, 12, 6);
    set_pins(2, 22, 12);
    set_pins(3, 33, 20);
    pin_mask = 4'b1111;
    capture_frame("four", 1'b1, -1, -1);
    check_flagged("four", 4 * BW * BH);
  endtask

  task automatic test_edge_clip();
    set_pins(0, HA - 2, VA - 1);
    set_pins(1, 16'hFFFF, 0);
    set_pins(2, 0, 16'hFFFF);
    pin_mask = 4'b0111;
    capture_frame("edge", 1'b1, -1, -1);
    check_flagged("edge", 2);
  endtask

  task automatic test_shadow_and_stop();
    int bad = 0;
    logic [15:0] cnt_before;
    set_pins(0, 5, 4);
    pin_mask = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      nxt_ph[k] = pin_ph[k];
      nxt_pv[k] = pin_pv[k];
    end
    nxt_ph[0] = 16'(HA - 1);
    nxt_pv[0] = 16'd10;
    nxt_mask = 4'b0001;
    capture_frame("move_old", 1'b1, 10, -1);
    check_flagged("move_old", BW * BH);
    capture_frame("move_new", 1'b1, -1, 12);
    check_flagged("move_new", BH);
    cnt_before = o_fcnt;
    repeat (VB + 3 * (HA + HB)) begin
      @(negedge clk);
      if (o_vs !== 1'b0 || o_hs !== 1'b0 || o_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || o_fcnt !== cnt_before) begin
      errors++;
      $display("FAIL stop_idle active_cycles=%0d cnt=%0d required 0 and cnt=%0d", bad, o_fcnt, cnt_before);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) set_pins(k, rand_coord(HA), rand_coord(VA));
    pin_mask = 4'($urandom_range(0, 15));
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        nxt_ph[k] = rand_coord(HA);
        nxt_pv[k] = rand_coord(VA);
      end
      nxt_mask = 4'($urandom_range(1, 15));
      capture_frame($sformatf("rand%0d", i), i > 0, int'($urandom_range(0, VA - 1)), -1);
    end
  endtask

  task automatic test_reset_midframe();
    int guard = 0, low = 0;
    while (!(o_vs === 1'b1 && o_h === 16'd17 && o_v === 16'd5) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!(o_vs === 1'b1 && o_h === 16'd17 && o_v === 16'd5)) begin
      errors++;
      $display("FAIL midreset_reach H=%0d V=%0d required H=17 V=5", o_h, o_v);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_vs, o_hs, o_flag, o_done, o_h, o_v, o_fcnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs VS=%b HS=%b F=%b D=%b H=%0d V=%0d CNT=%0d required all 0",
               o_vs, o_hs, o_flag, o_done, o_h, o_v, o_fcnt);
    end
    exp_fcnt = 0;
    rst_n = 1'b1;
    guard = 0;
    while (guard < 20) begin
      @(negedge clk);
      guard++;
      if (o_vs === 1'b1) break;
      low++;
    end
    checks++;
    if (low !== VB || o_vs !== 1'b1 || o_hs !== 1'b1 || o_h !== 16'd0 || o_v !== 16'd0) begin
      errors++;
      $display("FAIL midreset_restart gap=%0d VS=%b HS=%b H=%0d V=%0d required gap=%0d VS=1 HS=1 H=0 V=0",
               low, o_vs, o_hs, o_h, o_v, VB);
    end
  endtask

  initial begin
    test_reset();
    test_plain_frames();
    test_single_blob();
    test_four_blobs();
    test_edge_clip();
    test_shadow_and_stop();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
